gpzda_frame_controller: RTL and testbench

Sequences the `$GPZDA` header comparer and parses the rest of each NMEA ZDA sentence from the byte stream. It sits between the UART byte receiver and the time/date consumers. It drives the comparer's restart/load inputs, takes over the stream once the header resolves, and extracts time and date fields. It verifies the XOR checksum and publishes BCD time/date with a one-cycle valid pulse.

---
 rtl/gpzda_frame_controller.sv | 136 +++++++++++++
 tb/tb_gpzda_frame_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gpzda_frame_controller.sv
// gpzda_frame_controller: sequences the $GPZDA header comparer, parses ZDA time/date fields,
// verifies the XOR checksum and publishes BCD time/date with one-cycle valid/error pulses.
module gpzda_frame_controller #(
    parameter int B       = 8,
    parameter int MAX_LEN = 82
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [B-1:0] data,
    output logic         cmp_restart,
    output logic         cmp_load,
    output logic [B-1:0] cmp_data,
    input  logic         cmp_resolve,
    input  logic         cmp_reject,
    output logic [23:0]  time_bcd,
    output logic [31:0]  date_bcd,
    output logic         valid,
    output logic         error,
    output logic         busy
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] L_MAX = CW'(MAX_LEN);

    typedef enum logic [3:0] {HUNT, SEP0, TIME, FRAC, DAY, MONTH, YEAR, SKIP, CK_HI, CK_LO} state_t;

    state_t        r_state;
    logic [7:0]    r_ck;
    logic [3:0]    r_ck_hi;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_n;
    logic [23:0]   r_time;
    logic [31:0]   r_date;
    logic [23:0]   r_time_bcd;
    logic [31:0]   r_date_bcd;
    logic          r_valid;
    logic          r_error;

    state_t     w_next;
    logic       w_abort;
    logic       w_ok;
    logic       w_bad;
    logic       w_digit;
    logic       w_comma;
    logic       w_hex_ok;
    logic [3:0] w_hex;
    logic [2:0] w_len;
    logic       w_match;
    logic       w_unused;

    assign w_unused = cmp_reject;
    assign w_digit  = data >= "0" && data <= "9";
    assign w_comma  = data == ",";
    assign w_hex_ok = w_digit || (data >= "A" && data <= "F");
    assign w_hex    = w_digit ? data[3:0] : data[3:0] + 4'd9;
    assign w_len    = r_state == TIME ? 3'd6 : r_state == YEAR ? 3'd4 : 3'd2;
    assign w_match  = {r_ck_hi, w_hex} == r_ck;

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        w_ok    = 1'b0;
        w_bad   = 1'b0;
        if (load) begin
            if (r_state == HUNT) w_next = cmp_resolve ? SEP0 : HUNT;
            else if (r_cnt == L_MAX || data == "$") w_abort = 1'b1;
            else case (r_state)
                SEP0: if (w_comma) w_next = TIME; else w_abort = 1'b1;
                TIME, DAY, MONTH, YEAR:
                    if (r_n < w_len) w_abort = !w_digit;
                    else if (w_comma) w_next = r_state == TIME ? DAY : r_state == DAY ? MONTH : r_state == MONTH ? YEAR : SKIP;
                    else if (r_state == TIME && data == ".") w_next = FRAC;
                    else w_abort = 1'b1;
                FRAC: if (w_comma) w_next = DAY; else w_abort = !w_digit;
                SKIP: if (data == "*") w_next = CK_HI;
                CK_HI: if (w_hex_ok) w_next = CK_LO; else w_abort = 1'b1;
                CK_LO: begin
                    w_next  = HUNT;
                    w_abort = !w_hex_ok;
                    w_ok    = w_hex_ok && w_match;
                    w_bad   = w_hex_ok && !w_match;
                end
                default: w_abort = 1'b1;
            endcase
            if (w_abort) w_next = HUNT;
        end
    end

    // A '$' seen mid-sentence is handed to the comparer in the same cycle it restarts.
    assign cmp_restart = !reset_n || (r_state != HUNT && w_next == HUNT);
    assign cmp_load    = r_state == HUNT ? load : load && data == "$";
    assign cmp_data    = data;
    assign time_bcd    = r_time_bcd;
    assign date_bcd    = r_date_bcd;
    assign valid       = r_valid;
    assign error       = r_error;
    assign busy        = r_state != HUNT;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= HUNT;
            r_ck       <= '0;
            r_ck_hi    <= '0;
            r_cnt      <= '0;
            r_n        <= '0;
            r_time     <= '0;
            r_date     <= '0;
            r_time_bcd <= '0;
            r_date_bcd <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_ok;
            r_error <= w_abort | w_bad;
            if (load && r_state != HUNT) begin
                if (r_cnt != L_MAX) r_cnt <= r_cnt + 1'b1;
                if (r_state inside {SEP0, TIME, FRAC, DAY, MONTH, YEAR, SKIP} && data != "*") r_ck <= r_ck ^ data[7:0];
                r_n <= w_next != r_state ? 3'd0 : r_n + {2'b0, w_digit};
                if (w_digit && r_state == TIME) r_time <= {r_time[19:0], data[3:0]};
                if (w_digit && r_state == DAY) r_date[7:0] <= {r_date[3:0], data[3:0]};
                if (w_digit && r_state == MONTH) r_date[15:8] <= {r_date[11:8], data[3:0]};
                if (w_digit && r_state == YEAR) r_date[31:16] <= {r_date[27:16], data[3:0]};
                if (r_state == CK_HI) r_ck_hi <= w_hex;
            end else if (load && cmp_resolve) begin
                r_ck  <= 8'h48;
                r_cnt <= '0;
                r_n   <= '0;
            end
            if (w_ok) begin
                r_time_bcd <= r_time;
                r_date_bcd <= r_date;
            end
        end
    end
endmodule

// File: tb/tb_gpzda_frame_controller.sv
// tb_gpzda_frame_controller: directed ZDA sentences against the frame controller,
// with a small behavioural $GPZDA header comparer closing the loop.
module tb_gpzda_frame_controller;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        cmp_restart, cmp_load, cmp_resolve;
    logic        cmp_reject = 1'b0;
    logic [7:0]  cmp_data;
    logic [23:0] time_bcd;
    logic [31:0] date_bcd;
    logic        valid, error, busy;
    logic [39:0] r_hist = 40'h0;

    int n_chk = 0, n_err = 0;
    int n_valid = 0, n_error = 0, n_both = 0;
    int v0, e0;

    gpzda_frame_controller dut (
        .clock(clock), .reset_n(reset_n), .load(load), .data(data),
        .cmp_restart(cmp_restart), .cmp_load(cmp_load), .cmp_data(cmp_data),
        .cmp_resolve(cmp_resolve), .cmp_reject(cmp_reject),
        .time_bcd(time_bcd), .date_bcd(date_bcd),
        .valid(valid), .error(error), .busy(busy)
    );

    always #5 clock = ~clock;

    // Header comparer: resolves when 'A' is loaded right after "$GPZD" since the last restart.
    assign cmp_resolve = cmp_load && cmp_data == "A" && r_hist == "$GPZD";
    always @(posedge clock)
        if (cmp_restart) r_hist <= cmp_load ? {32'h0, cmp_data} : 40'h0;
        else if (cmp_load) r_hist <= {r_hist[31:0], cmp_data};

    always @(negedge clock) begin
        if (valid) n_valid++;
        if (error) n_error++;
        if (valid && error) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        load = 1'b1;
        data = b;
        @(posedge clock);
        #1;
        load = 1'b0;
    endtask

    task automatic send_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_good(input string tag);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_time"}, time_bcd, 24'h201530);
        chk({tag, "_date"}, date_bcd, 32'h20020704);
    endtask

    initial begin
        #2;
        chk("rst_restart", cmp_restart, 1);
        chk("rst_time", time_bcd, 0);
        chk("rst_date", date_bcd, 0);
        chk("rst_valid", valid, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Scenario 1: back-to-back good sentence
        v0 = n_valid;
        e0 = n_error;
        send_str("$GPZDA,2", 0);
        chk("s1_busy_mid", busy, 1);
        load = 1'b1;
        data = "0";
        #1;
        chk("s1_cmp_load_off", cmp_load, 0);
        chk("s1_cmp_data", cmp_data, "0");
        @(posedge clock);
        #1;
        load = 1'b0;
        send_str("1530.00,04,07,2002,00,00*6", 0);
        load = 1'b1;
        data = "0";
        #1;
        chk("s1_restart_end", cmp_restart, 1);
        @(posedge clock);
        #1;
        load = 1'b0;
        check_good("s1");
        @(posedge clock);
        #1;
        chk("s1_valid_drop", valid, 0);
        chk("s1_nvalid", n_valid - v0, 1);
        chk("s1_nerror", n_error - e0, 0);

        // Scenario 2: bad checksum keeps previous outputs
        v0 = n_valid;
        send_str("$GPZDA,201530.00,04,07,2002,00,00*61", 0);
        chk("s2_error", error, 1);
        chk("s2_valid", valid, 0);
        chk("s2_busy", busy, 0);
        chk("s2_time", time_bcd, 24'h201530);
        chk("s2_date", date_bcd, 32'h20020704);
        @(posedge clock);
        #1;
        chk("s2_error_drop", error, 0);
        chk("s2_nvalid", n_valid - v0, 0);

        // Scenario 6 + 3: reset mid-sentence, then the sentence with random gaps
        send_str("$GPZDA,2015", 0);
        reset_n = 1'b0;
        #1;
        chk("s6_restart", cmp_restart, 1);
        chk("s6_time", time_bcd, 0);
        chk("s6_date", date_bcd, 0);
        chk("s6_busy", busy, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        v0 = n_valid;
        e0 = n_error;
        send_str("$GPZDA,201530.00,04,07,2002,00,00*60", 5);
        check_good("s3");
        @(posedge clock);
        #1;
        chk("s3_nvalid", n_valid - v0, 1);
        chk("s3_nerror", n_error - e0, 0);

        // Scenario 4: '$' mid-sentence restarts the header match
        v0 = n_valid;
        e0 = n_error;
        send_str("$GPZDA,20", 0);
        load = 1'b1;
        data = "$";
        #1;
        chk("s4_restart", cmp_restart, 1);
        chk("s4_cmp_load", cmp_load, 1);
        @(posedge clock);
        #1;
        load = 1'b0;
        chk("s4_error", error, 1);
        chk("s4_busy", busy, 0);
        send_str("GPZDA,201530.00,04,07,2002,00,00*60", 0);
        check_good("s4");
        @(posedge clock);
        #1;
        chk("s4_nvalid", n_valid - v0, 1);
        chk("s4_nerror", n_error - e0, 1);

        // Scenario 5: empty fields abort on the second ','
        v0 = n_valid;
        e0 = n_error;
        send_str("$GPZDA,,", 0);
        chk("s5_error", error, 1);
        chk("s5_busy", busy, 0);
        send_str(",,,,*48", 0);
        @(posedge clock);
        #1;
        chk("s5_nvalid", n_valid - v0, 0);
        chk("s5_nerror", n_error - e0, 1);

        chk("valid_and_error", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
